// File: rtl/uart_pkg.sv
// Shared UART types and helpers: state encoding, parity-mode constants and
// frame-length helper. Parity support is compiled in only when the macro
// UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;
`else
    localparam bit PAR_BUILD = 1'b0;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } tx_state_e;
`endif

    // Serial bits in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_bits, input int stop_bits,
                                      input int parity);
        int n;
        n = 1 + data_bits + stop_bits;
        if (PAR_BUILD && (parity != PAR_NONE)) n = n + 1;
        return n;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// cycle of each bit. restart holds the count at zero (used while idle).
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = !restart && (cnt == LAST);

    // Free-running within a frame, wraps to zero at the end of every bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (restart || tick)  cnt <= '0;
        else                       cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS payload LSB first, optional
// parity bit, STOP_BITS stop bits. Parity logic and the parity state exist
// only when UART_TX_PARITY_EN is defined; otherwise PARITY is ignored.
// A new payload may be accepted in the final stop cycle so frames can run
// back to back with no idle gap.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 data_valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 data_ready,
    output logic                 uart_txd,
    output logic                 busy
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2) begin : g_cfg_err
        $error("uart_tx_framer: illegal parameter combination");
    end

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON  = (PARITY != PAR_NONE);
    localparam bit PAR_INV = (PARITY == PAR_ODD);
    logic par_q, par_d;
`endif

    tx_state_e            state, state_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic [BW-1:0]        bit_idx, bit_idx_d;
    logic                 stop_idx, stop_idx_d;
    logic                 stop_last;
    logic                 txd_q, txd_d;
    logic                 rdy_en;
    logic                 ready_c;
    logic                 accept;
    logic                 tick;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (state == ST_IDLE),
        .tick    (tick)
    );

    assign stop_last = (STOP_BITS == 1) || stop_idx;
    assign busy      = (state != ST_IDLE);
    assign uart_txd  = txd_q;

    // Ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    // Next-state, handshake and next serial-line value.
    always_comb begin
        state_d    = state;
        shreg_d    = shreg;
        bit_idx_d  = bit_idx;
        stop_idx_d = stop_idx;
        ready_c    = 1'b0;
        txd_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state)
            ST_IDLE: ready_c = 1'b1;
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shreg_d = shreg >> 1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PAR_ON ? ST_PARITY : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (stop_last) begin
                        ready_c = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        data_ready = ready_c && rdy_en;
        accept     = data_ready && data_valid;
        if (accept) begin
            state_d = ST_START;
            shreg_d = data;
`ifdef UART_TX_PARITY_EN
            par_d   = (^data) ^ PAR_INV;
`endif
        end

        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    // Frame state and registered serial output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_idx  <= bit_idx_d;
            stop_idx <= stop_idx_d;
            txd_q    <= txd_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the captured payload, held for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per serial bit (legal 2..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..9).
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even (honoured only per REQ-024).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port data_valid  input  1  source offers a byte.
REQ-008 SHALL have port data  input  DATA_BITS  payload, LSB transmitted first.
REQ-009 SHALL have port data_ready  output  1  block can accept a payload this cycle.
REQ-010 SHALL have port uart_txd  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  frame in progress.

Function
REQ-012 SHALL accept a payload on any rising edge where data_valid and data_ready are both high; data is captured into an internal shift register.
REQ-013 SHALL drive data_ready high in IDLE and in the final cycle of the last stop bit, low otherwise.
REQ-014 SHALL use states IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA; DATA->PARITY after DATA_BITS bits if parity enabled, else ->STOP; PARITY->STOP; STOP->START if accepted in final stop cycle, else ->IDLE.
REQ-015 SHALL begin driving the start bit (0) on the cycle after acceptance (latency 1 clk).
REQ-016 SHALL hold every start, data, parity and stop bit on uart_txd for exactly CLKS_PER_BIT cycles; no bit may be shortened or lengthened by state transitions.
REQ-017 SHALL transmit data bits LSB first, then parity bit (if enabled), then STOP_BITS high bits.
REQ-018 SHALL compute parity as XOR of the captured payload (even) or its inverse (odd).
REQ-019 SHALL support back-to-back frames with no idle gap when data_valid is high in the final stop cycle.
REQ-020 SHALL assert busy in all states except IDLE; uart_txd SHALL be registered (glitch-free).
REQ-021 SHALL ignore data and data_valid while data_ready is low; payload changes mid-frame SHALL NOT alter the frame.
REQ-022 SHALL size the bit-period counter as clog2(CLKS_PER_BIT) bits and the bit index as clog2(DATA_BITS+1) bits; counter wraps to 0 at CLKS_PER_BIT-1.

Reset
REQ-023 SHALL, on rst_n low (asynchronous, including mid-frame), force state IDLE, counters 0, uart_txd 1, busy 0, data_ready 0 while rst_n low and 1 from the first rising edge after deassertion.

Configuration
REQ-024 SHALL compile parity logic and the PARITY state only when macro UART_TX_PARITY_EN is defined; without it PARITY is ignored, frames carry no parity bit, and the PARITY state does not exist.

Structure
REQ-025 SHALL take the state enum type, parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and frame-length helper function from shared package uart_pkg.
REQ-026 SHALL instantiate one sub-module uart_baud_tick (bit-period counter with restart input and end-of-bit tick output, parametrised by CLKS_PER_BIT).

Verification
REQ-027 SHALL verify CLKS_PER_BIT=4, DATA_BITS=8, no parity, send 0xA5 -> txd 0,1,0,1,0,0,1,0,1,1 each held 4 cycles, start bit begins 1 cycle after accept.
REQ-028 SHALL verify with UART_TX_PARITY_EN, PARITY=2, send 0x07 -> parity bit 1; PARITY=1 -> parity bit 0; frame 11 bits x CLKS_PER_BIT.
REQ-029 SHALL verify data_valid held high for bytes 0x55 then 0xAA -> second start bit immediately follows first stop bit, zero idle cycles, busy stays high.
REQ-030 SHALL verify rst_n pulsed low in DATA bit 3 -> uart_txd=1, busy=0 immediately (asynchronously); next accepted byte sends a complete frame.
REQ-031 SHALL verify STOP_BITS=2, DATA_BITS=5, send 0x1F -> 5 data bits of 1 then 2 stop bits, total 8 x CLKS_PER_BIT cycles; data_ready low until final stop cycle.
REQ-032 SHALL verify data changed and data_valid toggled mid-frame -> transmitted bits match captured payload only.
